// File: rtl/chunked_serial_adder_pkg.sv
// Shared FSM encodings and sizing helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned ncyc);
        return (clog2(ncyc) < 1) ? 1 : clog2(ncyc);
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_ripple_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_top
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_top = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry between chunks.
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int unsigned NCYC = WIDTH / CHUNK;
    localparam int unsigned CW   = cnt_width(NCYC);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry_q, co_q, v_q;

    int unsigned      offset;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             chunk_co, chunk_c_top;
    logic             last;
    logic [WIDTH-1:0] s_merged;

    always_comb begin
        offset   = 32'(cnt_q) * CHUNK;
        a_chunk  = CHUNK'(a_q >> offset);
        b_chunk  = CHUNK'(b_q >> offset);
        last     = (cnt_q == CW'(NCYC - 1));
        s_merged = (s_q & ~(CHUNK_MASK << offset)) | (WIDTH'(sum_chunk) << offset);
    end

    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry_q),
        .sum   (sum_chunk),
        .co    (chunk_co),
        .c_top (chunk_c_top)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        // Subtraction folds into addition of the inverted operand.
                        b_q     <= B ^ {WIDTH{SUB}};
                        carry_q <= Ci;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_q     <= s_merged;
                    carry_q <= chunk_co;
                    if (last) begin
                        co_q    <= chunk_co;
                        v_q     <= chunk_co ^ chunk_c_top;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign Co        = co_q;
    assign V         = v_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and randomised checks of chunked_serial_adder in 16/4, 16/16 and 8/1 builds.
module tb_chunked_serial_adder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [15:0] a_in      [3];
    logic [15:0] b_in      [3];
    logic        ci_in     [3];
    logic        sub_in    [3];

    logic        in_ready  [3];
    logic        out_valid [3];
    logic        co_out    [3];
    logic        v_out     [3];
    logic [15:0] s_out     [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, v0, v1, v2;
    logic [15:0] s0, s1;
    logic [7:0]  s2;

    assign in_ready[0] = ir0;  assign in_ready[1] = ir1;  assign in_ready[2] = ir2;
    assign out_valid[0] = ov0; assign out_valid[1] = ov1; assign out_valid[2] = ov2;
    assign co_out[0] = co0;    assign co_out[1] = co1;    assign co_out[2] = co2;
    assign v_out[0] = v0;      assign v_out[1] = v1;      assign v_out[2] = v2;
    assign s_out[0] = s0;      assign s_out[1] = s1;      assign s_out[2] = {8'h00, s2};

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(ir0),
        .A(a_in[0]), .B(b_in[0]), .Ci(ci_in[0]), .SUB(sub_in[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .S(s0), .Co(co0), .V(v0)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut_wide (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(ir1),
        .A(a_in[1]), .B(b_in[1]), .Ci(ci_in[1]), .SUB(sub_in[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .S(s1), .Co(co1), .V(v1)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_bit (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(ir2),
        .A(a_in[2][7:0]), .B(b_in[2][7:0]), .Ci(ci_in[2]), .SUB(sub_in[2]),
        .out_valid(ov2), .out_ready(out_ready[2]), .S(s2), .Co(co2), .V(v2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Independent arithmetic model: w-bit add of A and (optionally inverted) B plus Ci.
    task automatic ref_op(input int w, input logic [15:0] aa, input logic [15:0] bb,
                          input logic cc, input logic sb,
                          output logic [15:0] es, output logic eco, output logic ev);
        logic [15:0] mask;
        logic [15:0] a_m, b_m;
        logic [16:0] full;
        mask = 16'((17'd1 << w) - 17'd1);
        a_m  = aa & mask;
        b_m  = (sb ? ~bb : bb) & mask;
        full = {1'b0, a_m} + {1'b0, b_m} + 17'(cc);
        es   = full[15:0] & mask;
        eco  = full[w];
        ev   = (a_m[w-1] == b_m[w-1]) && (es[w-1] != a_m[w-1]);
    endtask

    // Called and returns at a falling edge; the DUT is left idle.
    task automatic run_op(input int d, input logic [15:0] aa, input logic [15:0] bb,
                          input logic cc, input logic sb, input logic [15:0] es,
                          input logic eco, input logic ev, input int elat, input string nm);
        int n;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " in_ready"}, 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1; a_in[d] = aa; b_in[d] = bb; ci_in[d] = cc; sub_in[d] = sb;
        out_ready[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0; a_in[d] = ~aa; b_in[d] = 16'($urandom); ci_in[d] = ~cc;
        sub_in[d] = ~sb;
        n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " S"}, 32'(s_out[d]), 32'(es));
        chk({nm, " Co"}, 32'(co_out[d]), 32'(eco));
        chk({nm, " V"}, 32'(v_out[d]), 32'(ev));
        @(negedge clk);
        chk({nm, " pulse end"}, {30'd0, out_valid[d], in_ready[d]}, 32'b01);
    endtask

    initial begin
        vec_t        vecs [7];
        int          n;
        logic [15:0] ra, rb, es;
        logic        rc, rs, eco, ev;

        vecs[0] = '{a: 16'h1234, b: 16'h1111, ci: 1'b0, sub: 1'b0, s: 16'h2345, co: 1'b0, v: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, sub: 1'b0, s: 16'h0000, co: 1'b1, v: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, sub: 1'b0, s: 16'h8000, co: 1'b0, v: 1'b1};
        vecs[3] = '{a: 16'h0005, b: 16'h0007, ci: 1'b1, sub: 1'b1, s: 16'hFFFE, co: 1'b0, v: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h0001, ci: 1'b1, sub: 1'b1, s: 16'h7FFF, co: 1'b1, v: 1'b1};
        vecs[5] = '{a: 16'h00FF, b: 16'h0000, ci: 1'b1, sub: 1'b0, s: 16'h0100, co: 1'b0, v: 1'b0};
        vecs[6] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, sub: 1'b0, s: 16'h0000, co: 1'b1, v: 1'b1};

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1; a_in[d] = '0; b_in[d] = '0;
            ci_in[d] = 1'b0; sub_in[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset flags dut%0d", d), {30'd0, out_valid[d], in_ready[d]}, 32'b01);
            chk($sformatf("reset S dut%0d", d), 32'(s_out[d]), 32'd0);
            chk($sformatf("reset Co/V dut%0d", d), {30'd0, co_out[d], v_out[d]}, 32'd0);
        end

        for (int i = 0; i < 7; i++)
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, vecs[i].s, vecs[i].co,
                   vecs[i].v, 4, $sformatf("vec%0d", i));

        // Backpressure: result held while new operands wait outside.
        out_ready[0] = 1'b0; in_valid[0] = 1'b1;
        a_in[0] = 16'h1234; b_in[0] = 16'h1111; ci_in[0] = 1'b0; sub_in[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp latency", 32'(n), 32'd4);
        in_valid[0] = 1'b1; a_in[0] = 16'h0F0F; b_in[0] = 16'h0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d flags", k), {30'd0, out_valid[0], in_ready[0]}, 32'b10);
            chk($sformatf("bp hold%0d S", k), 32'(s_out[0]), 32'h2345);
            chk($sformatf("bp hold%0d Co/V", k), {30'd0, co_out[0], v_out[0]}, 32'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp back to idle", {30'd0, out_valid[0], in_ready[0]}, 32'b01);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp second latency", 32'(n), 32'd4);
        chk("bp second S", 32'(s_out[0]), 32'h1010);
        chk("bp second Co/V", {30'd0, co_out[0], v_out[0]}, 32'd0);
        @(negedge clk);

        // Reset lands on the second RUN cycle.
        in_valid[0] = 1'b1; a_in[0] = 16'h1234; b_in[0] = 16'h1111;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort flags", {30'd0, out_valid[0], in_ready[0]}, 32'b01);
        chk("abort S", 32'(s_out[0]), 32'd0);
        chk("abort Co/V", {30'd0, co_out[0], v_out[0]}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort quiet%0d", k), 32'(out_valid[0]), 32'd0);
        end
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4, "post abort");

        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 500; i++) begin
                ra = 16'($urandom); rb = 16'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                ref_op((d == 1) ? 16 : 8, ra, rb, rc, rs, es, eco, ev);
                run_op(d, (d == 1) ? ra : {8'h00, ra[7:0]}, (d == 1) ? rb : {8'h00, rb[7:0]},
                       rc, rs, es, eco, ev, (d == 1) ? 1 : 8, $sformatf("rand dut%0d #%0d", d, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
